// File: rtl/instance_scheduler_pkg.sv
// Payload types shared by the instance scheduler and its neighbours in the geometry front end.
package instance_scheduler_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned TF_ELEMS = 12;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    // 3x4 fixed-point matrix, row-major
    typedef struct packed {
        logic [TF_ELEMS-1:0][COORD_W-1:0] m;
    } transform_t;

    typedef struct packed {
        logic [7:0] model_id;
        transform_t transform;
    } modelinstance_t;

    typedef struct packed {
        triangle_t  triangle;
        transform_t transform;
    } triangle_tf_t;

    typedef struct packed {
        logic last;
    } triangle_metadata_t;

    typedef struct packed {
        triangle_tf_t data;
        logic         last;
    } sched_fifo_entry_t;

endpackage

// File: rtl/instance_scheduler.sv
// Accepts one model instance at a time, looks up its triangle range and streams
// the triangles, tagged with the instance transform, through a 2-entry output FIFO.
module instance_scheduler
    import instance_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned COUNT_W = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  modelinstance_t       inst_data,
    input  logic                 inst_last,
    output logic                 tbl_en,
    output logic [7:0]           tbl_addr,
    input  logic [ADDR_W-1:0]    tbl_base,
    input  logic [COUNT_W-1:0]   tbl_count,
    output logic                 tri_en,
    output logic [ADDR_W-1:0]    tri_addr,
    input  triangle_t            tri_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output triangle_tf_t         out_data,
    output triangle_metadata_t   out_meta,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned OCC_W      = 2;
    localparam int unsigned CREDIT_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t             state_q, state_d;

    logic               inst_ready_q;
    logic               tbl_en_q;
    logic [7:0]         tbl_addr_q;
    logic               frame_done_q;

    transform_t         tf_q;
    logic               last_q;
    logic [ADDR_W-1:0]  base_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] idx_q;

    // tag carried alongside the single outstanding triangle read
    logic               rd_pending_q;
    transform_t         rd_tf_q;
    logic               rd_last_q;

    sched_fifo_entry_t  fifo_q [FIFO_DEPTH];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;

    logic                inst_hs_c;
    logic                push_c;
    logic                pop_c;
    logic                issue_c;
    logic                is_final_c;
    logic [CREDIT_W-1:0] credits_c;
    sched_fifo_entry_t   head_c;
    sched_fifo_entry_t   push_entry_c;

    assign inst_hs_c  = inst_valid && inst_ready_q;
    assign push_c     = rd_pending_q;
    assign pop_c      = (occ_q != '0) && out_ready;
    assign is_final_c = (idx_q == count_q - COUNT_W'(1));
    assign head_c     = fifo_q[rd_ptr_q];

    // entries already committed to the FIFO, less the one leaving this cycle
    assign credits_c  = CREDIT_W'(occ_q) + CREDIT_W'(rd_pending_q) - CREDIT_W'(pop_c);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inst_hs_c) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = (tbl_count == '0) ? IDLE : STREAM;
            end
            STREAM: begin
                if (credits_c < CREDIT_W'(2)) begin
                    issue_c = 1'b1;
                    if (is_final_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // read strobes: the table port is registered, the triangle port must see this cycle's pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_ready_q <= 1'b0;
            tbl_en_q     <= 1'b0;
            tbl_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            inst_ready_q <= (state_d == IDLE);
            tbl_en_q     <= (state_d == LOOKUP);
            tbl_addr_q   <= (state_d == LOOKUP) ? inst_data.model_id : 8'd0;
            frame_done_q <= (pop_c && head_c.last)
                         || ((state_q == WAIT) && (tbl_count == '0) && last_q);
        end
    end

    // per-instance context and stream position
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tf_q    <= '0;
            last_q  <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            if ((state_q == IDLE) && inst_hs_c) begin
                tf_q   <= inst_data.transform;
                last_q <= inst_last;
            end
            if (state_q == WAIT) begin
                base_q  <= tbl_base;
                count_q <= tbl_count;
                idx_q   <= '0;
            end else if (issue_c) begin
                idx_q <= idx_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pending_q <= 1'b0;
            rd_tf_q      <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            rd_pending_q <= issue_c;
            if (issue_c) begin
                rd_tf_q   <= tf_q;
                rd_last_q <= last_q && is_final_c;
            end
        end
    end

    always_comb begin
        push_entry_c                = '0;
        push_entry_c.data.triangle  = tri_data;
        push_entry_c.data.transform = rd_tf_q;
        push_entry_c.last           = rd_last_q;
    end

    // output FIFO; push and pop in the same cycle leave occupancy unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push_c) begin
                fifo_q[wr_ptr_q] <= push_entry_c;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
        end
    end

    always_comb begin
        inst_ready    = inst_ready_q;
        tbl_en        = tbl_en_q;
        tbl_addr      = tbl_addr_q;
        tri_en        = issue_c;
        tri_addr      = issue_c ? (base_q + ADDR_W'(idx_q)) : '0;
        out_valid     = (occ_q != '0);
        out_data      = head_c.data;
        out_meta      = '0;
        out_meta.last = head_c.last;
        frame_done    = frame_done_q;
        busy          = (state_q != IDLE) || (occ_q != '0) || rd_pending_q;
    end

endmodule
